fifo_wconv: RTL and testbench

Synchronous FIFO with configurable width conversion between the write and read ports. Storage is kept in narrow (DATA_WIDTH) units. MODE selects the direction:
- MODE_DOWN: wide write, narrow read.
- MODE_UP: narrow write, wide read.

The ratio between the two port widths is RATIO. The block adds a fill level, almost-full/almost-empty thresholds and error pulses for rejected operations. It sits between a producer and a consumer of differing bus widths in the datapath.

---
 rtl/fifo_wconv_pkg.sv | 28 ++
 rtl/fifo_wconv_ctrl.sv | 86 ++++++++
 rtl/fifo_wconv.sv | 97 +++++++++
 tb/tb_fifo_wconv.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wconv_pkg.sv
// Shared types and width helpers for the width-converting FIFO.
// Port widths and per-access word counts derive from mode and ratio.
package fifo_wconv_pkg;

    typedef enum logic {
        MODE_DOWN = 1'b0,
        MODE_UP   = 1'b1
    } fifo_mode_e;

    function automatic int wn(input int ratio, input fifo_mode_e mode);
        return (mode == MODE_DOWN) ? ratio : 1;
    endfunction

    function automatic int rn(input int ratio, input fifo_mode_e mode);
        return (mode == MODE_DOWN) ? 1 : ratio;
    endfunction

    function automatic int wr_width(input int dw, input int ratio,
                                    input fifo_mode_e mode);
        return dw * wn(ratio, mode);
    endfunction

    function automatic int rd_width(input int dw, input int ratio,
                                    input fifo_mode_e mode);
        return dw * rn(ratio, mode);
    endfunction

endpackage

// File: rtl/fifo_wconv_ctrl.sv
// Pointer, occupancy and flag control for the width-converting FIFO.
// Counts are in narrow words; flags depend only on registered level.
module fifo_wconv_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int WN         = 2,
    parameter int RN         = 1,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_ok,
    output logic                  rd_ok,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(2 ** ADDR_WIDTH);
    localparam logic [LW-1:0] WN_L = LW'(WN);
    localparam logic [LW-1:0] RN_L = LW'(RN);
    localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L = LW'(AE_THRESH);
    localparam logic [ADDR_WIDTH-1:0] WN_P = ADDR_WIDTH'(WN);
    localparam logic [ADDR_WIDTH-1:0] RN_P = ADDR_WIDTH'(RN);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_err_q, rd_err_d;

    assign full         = (DEPTH_L - level_q) < WN_L;
    assign empty        = level_q < RN_L;
    assign almost_full  = level_q >= AF_L;
    assign almost_empty = level_q <= AE_L;
    assign wr_ok        = wr && !full;
    assign rd_ok        = rd && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + WN_P;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + RN_P;
        end
        level_d  = level_q + (wr_ok ? WN_L : '0) - (rd_ok ? RN_L : '0);
        wr_err_d = wr && full;
        rd_err_d = rd && empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign level  = level_q;
    assign wr_err = wr_err_q;
    assign rd_err = rd_err_q;

endmodule

// File: rtl/fifo_wconv.sv
// Synchronous FIFO with wide/narrow port conversion over narrow storage.
// Lane 0 (LSBs) is always the oldest narrow word on either side.
module fifo_wconv
    import fifo_wconv_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         RATIO      = 2,
    parameter int         ADDR_WIDTH = 3,
    parameter fifo_mode_e MODE       = MODE_DOWN,
    parameter int         AF_THRESH  = 2 ** ADDR_WIDTH - RATIO,
    parameter int         AE_THRESH  = RATIO,
    localparam int        WR_W = wr_width(DATA_WIDTH, RATIO, MODE),
    localparam int        RD_W = rd_width(DATA_WIDTH, RATIO, MODE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [WR_W-1:0]       w_data,
    input  logic                  rd,
    output logic [RD_W-1:0]       r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WN    = wn(RATIO, MODE);
    localparam int RN    = rn(RATIO, MODE);

    if (DEPTH < 2 * RATIO || RATIO < 1 || RATIO > 8 ||
        (RATIO & (RATIO - 1)) != 0) begin : g_bad_cfg
        $error("fifo_wconv: invalid RATIO/ADDR_WIDTH combination");
    end

    logic                  wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    fifo_wconv_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WN         (WN),
        .RN         (RN),
        .AF_THRESH  (AF_THRESH),
        .AE_THRESH  (AE_THRESH)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .wr_ok        (wr_ok),
        .rd_ok        (rd_ok),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_err       (wr_err),
        .rd_err       (rd_err)
    );

    // Wide accesses stay contiguous because DEPTH is a multiple of RATIO.
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            for (int i = 0; i < WN; i++) begin
                mem_d[wr_ptr + ADDR_WIDTH'(i)] =
                    w_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        r_data = '0;
        for (int i = 0; i < RN; i++) begin
            r_data[i*DATA_WIDTH +: DATA_WIDTH] =
                mem_q[rd_ptr + ADDR_WIDTH'(i)];
        end
    end

endmodule

// File: tb/tb_fifo_wconv.sv
// Bench for fifo_wconv: queue-based model per instance plus literal checks.
// Covers a DOWN (2:1, depth 8) and an UP (1:4, depth 16) configuration.
module tb_fifo_wconv;
    import fifo_wconv_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DOWN instance signals
    logic        wr_d = 1'b0, rd_d = 1'b0;
    logic [15:0] w_data_d = '0;
    logic [7:0]  r_data_d;
    logic        full_d, empty_d, af_d, ae_d, wr_err_d, rd_err_d;
    logic [3:0]  level_d;

    // UP instance signals
    logic        wr_u = 1'b0, rd_u = 1'b0;
    logic [7:0]  w_data_u = '0;
    logic [31:0] r_data_u;
    logic        full_u, empty_u, af_u, ae_u, wr_err_u, rd_err_u;
    logic [4:0]  level_u;

    fifo_wconv #(
        .DATA_WIDTH (8), .RATIO (2), .ADDR_WIDTH (3), .MODE (MODE_DOWN)
    ) dut_d (
        .clk (clk), .reset (reset), .wr (wr_d), .w_data (w_data_d),
        .rd (rd_d), .r_data (r_data_d), .full (full_d), .empty (empty_d),
        .almost_full (af_d), .almost_empty (ae_d), .level (level_d),
        .wr_err (wr_err_d), .rd_err (rd_err_d)
    );

    fifo_wconv #(
        .DATA_WIDTH (8), .RATIO (4), .ADDR_WIDTH (4), .MODE (MODE_UP)
    ) dut_u (
        .clk (clk), .reset (reset), .wr (wr_u), .w_data (w_data_u),
        .rd (rd_u), .r_data (r_data_u), .full (full_u), .empty (empty_u),
        .almost_full (af_u), .almost_empty (ae_u), .level (level_u),
        .wr_err (wr_err_u), .rd_err (rd_err_u)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of narrow words per instance.
    logic [7:0] qd[$];
    logic [7:0] qu[$];
    logic       xwe_d = 1'b0, xre_d = 1'b0, xwe_u = 1'b0, xre_u = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qd.delete();
            qu.delete();
            xwe_d <= 1'b0; xre_d <= 1'b0;
            xwe_u <= 1'b0; xre_u <= 1'b0;
        end else begin
            int nd, nu;
            nd = qd.size();
            nu = qu.size();
            xwe_d <= wr_d && (8 - nd) < 2;
            xre_d <= rd_d && nd < 1;
            xwe_u <= wr_u && (16 - nu) < 1;
            xre_u <= rd_u && nu < 4;
            if (rd_d && nd >= 1) void'(qd.pop_front());
            if (wr_d && (8 - nd) >= 2) begin
                qd.push_back(w_data_d[7:0]);
                qd.push_back(w_data_d[15:8]);
            end
            if (rd_u && nu >= 4) begin
                for (int i = 0; i < 4; i++) void'(qu.pop_front());
            end
            if (wr_u && nu < 16) qu.push_back(w_data_u);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            int nd, nu;
            nd = qd.size();
            nu = qu.size();
            chk("d_level", 32'(level_d), 32'(nd));
            chk("d_empty", 32'(empty_d), 32'(nd < 1));
            chk("d_full", 32'(full_d), 32'(8 - nd < 2));
            chk("d_af", 32'(af_d), 32'(nd >= 6));
            chk("d_ae", 32'(ae_d), 32'(nd <= 2));
            chk("d_wr_err", 32'(wr_err_d), 32'(xwe_d));
            chk("d_rd_err", 32'(rd_err_d), 32'(xre_d));
            if (nd >= 1) chk("d_r_data", 32'(r_data_d), 32'(qd[0]));
            chk("u_level", 32'(level_u), 32'(nu));
            chk("u_empty", 32'(empty_u), 32'(nu < 4));
            chk("u_full", 32'(full_u), 32'(nu >= 16));
            chk("u_af", 32'(af_u), 32'(nu >= 12));
            chk("u_ae", 32'(ae_u), 32'(nu <= 4));
            chk("u_wr_err", 32'(wr_err_u), 32'(xwe_u));
            chk("u_rd_err", 32'(rd_err_u), 32'(xre_u));
            if (nu >= 4) chk("u_r_data", r_data_u, {qu[3], qu[2], qu[1], qu[0]});
        end
    end

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic op_d(input logic w, input logic [15:0] d, input logic r);
        wr_d = w; w_data_d = d; rd_d = r;
        @(posedge clk);
        #1;
        wr_d = 1'b0; rd_d = 1'b0;
    endtask

    task automatic op_u(input logic w, input logic [7:0] d, input logic r);
        wr_u = w; w_data_u = d; rd_u = r;
        @(posedge clk);
        #1;
        wr_u = 1'b0; rd_u = 1'b0;
    endtask

    logic [7:0]  seq3 [8] = '{8'h17, 8'h19, 8'hCD, 8'h21,
                              8'hCE, 8'h25, 8'h7B, 8'h2A};
    logic [15:0] fill3 [4] = '{16'h1917, 16'h21CD, 16'h25CE, 16'h2A7B};

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_empty", 32'(empty_d), 32'd1);
        chk("rst_full", 32'(full_d), 32'd0);
        chk("rst_level", 32'(level_d), 32'd0);
        chk("rst_ae", 32'(ae_d), 32'd1);
        chk("rst_af", 32'(af_d), 32'd0);
        chk("rst_r_data", 32'(r_data_d), 32'd0);
        chk("rst_errs", 32'({wr_err_d, rd_err_d}), 32'd0);

        op_d(1'b1, 16'h1917, 1'b0);
        chk("t2_level", 32'(level_d), 32'd2);
        chk("t2_empty", 32'(empty_d), 32'd0);
        chk("t2_rdata0", 32'(r_data_d), 32'h17);
        op_d(1'b0, '0, 1'b1);
        chk("t2_rdata1", 32'(r_data_d), 32'h19);
        chk("t2_level1", 32'(level_d), 32'd1);
        op_d(1'b0, '0, 1'b1);
        chk("t2_empty2", 32'(empty_d), 32'd1);

        for (int i = 0; i < 4; i++) op_d(1'b1, fill3[i], 1'b0);
        chk("t3_level", 32'(level_d), 32'd8);
        chk("t3_full", 32'(full_d), 32'd1);
        chk("t3_af", 32'(af_d), 32'd1);
        op_d(1'b1, 16'h628B, 1'b0);
        chk("t3_wr_err", 32'(wr_err_d), 32'd1);
        chk("t3_level_hold", 32'(level_d), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t3_seq", 32'(r_data_d), 32'(seq3[i]));
            op_d(1'b0, '0, 1'b1);
        end
        chk("t3_empty", 32'(empty_d), 32'd1);

        op_d(1'b1, 16'h1E20, 1'b1);
        chk("t4_rd_err", 32'(rd_err_d), 32'd1);
        chk("t4_level", 32'(level_d), 32'd2);
        chk("t4_rdata", 32'(r_data_d), 32'h20);
        op_d(1'b0, '0, 1'b1);
        op_d(1'b0, '0, 1'b1);

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) op_d(1'b1, 16'($urandom), 1'b0);
            for (int j = 0; j < 8; j++) op_d(1'b0, '0, 1'b1);
        end
        op_d(1'b1, 16'hB2A1, 1'b0);
        op_d(1'b1, 16'hB4B3, 1'b0);
        op_d(1'b1, 16'hB6B5, 1'b0);
        chk("t5_level6", 32'(level_d), 32'd6);
        op_d(1'b1, 16'hB8B7, 1'b1);
        chk("t5_level7", 32'(level_d), 32'd7);
        chk("t5_head", 32'(r_data_d), 32'hB2);
        for (int j = 0; j < 3; j++) op_d(1'b0, '0, 1'b1);
        chk("t5_wrap", 32'(r_data_d), 32'hB5);
        wr_d = 1'b1; w_data_d = 16'h5A5A;
        #3 reset = 1'b1;
        #1;
        chk("t5_rst_empty", 32'(empty_d), 32'd1);
        chk("t5_rst_level", 32'(level_d), 32'd0);
        wr_d = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        op_d(1'b1, 16'hABCD, 1'b0);
        chk("t5_post_rst", 32'(r_data_d), 32'hCD);
        chk("t5_post_lvl", 32'(level_d), 32'd2);

        op_u(1'b1, 8'h11, 1'b0);
        op_u(1'b1, 8'h22, 1'b0);
        op_u(1'b1, 8'h33, 1'b0);
        chk("t6_empty3", 32'(empty_u), 32'd1);
        op_u(1'b1, 8'h44, 1'b0);
        chk("t6_empty4", 32'(empty_u), 32'd0);
        chk("t6_rdata", r_data_u, 32'h44332211);
        op_u(1'b0, '0, 1'b1);
        chk("t6_level0", 32'(level_u), 32'd0);
        for (int i = 0; i < 16; i++) op_u(1'b1, 8'(8'hA0 + i), 1'b0);
        chk("t6_full", 32'(full_u), 32'd1);
        chk("t6_rdata_f", r_data_u, 32'hA3A2A1A0);
        op_u(1'b1, 8'hFF, 1'b0);
        chk("t6_wr_err", 32'(wr_err_u), 32'd1);
        for (int j = 0; j < 5; j++) op_u(1'b0, '0, 1'b1);
        chk("t6_rd_err", 32'(rd_err_u), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
